ram_port_arbiter: RTL and testbench

- Shares one single-ported data RAM between two requesters: instruction fetch (IF, read-only) and the memory stage (MEM, read/write with a 64-bit byte-lane bit mask).
- Sits between the IF/MEM stage RAM outputs and the RAM model.
- Arbitrates, latches the winning request, sequences the RAM access over a fixed read latency, and returns data with a one-cycle done pulse that the pipeline uses as its stall release.

---
 rtl/ram_port_arbiter_if.sv | 46 ++++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IF/MEM request ports and RAM-side bus of ram_port_arbiter.
// master: arbiter view (takes requests, drives RAM); slave: pipeline + RAM model.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_wmask;
    logic              mem_gnt;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_wmask;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_done, if_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_done, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
        input  ram_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_done, if_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_done, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask,
        output ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between IF (read-only) and MEM (read/write).
// Ports: clk, rst (async, active-high), bus (ram_port_arbiter_if.master):
//   if_req/if_addr -> if_gnt/if_done/if_rdata,
//   mem_req/we/addr/wdata/wmask -> mem_gnt/mem_done/mem_rdata,
//   ram_en/we/addr/wdata/wmask -> RAM, ram_rdata <- RAM.
// Macro ARB_RR_EN: two-way round-robin on ties; undefined = MEM priority.
module ram_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input logic                clk,
    input logic                rst,
    ram_port_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wmask_q, wmask_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic any_req;
    logic pick_mem;
    logic grant;
    logic issue;

    assign any_req = bus.if_req | bus.mem_req;

`ifdef ARB_RR_EN
    logic last_mem_q, last_mem_d;

    // On a tie the port not granted last wins; a lone requester always wins.
    assign pick_mem = bus.mem_req & (~bus.if_req | ~last_mem_q);

    always_comb begin
        last_mem_d = last_mem_q;
        if (grant) begin
            last_mem_d = pick_mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mem_q <= 1'b0;
        end else begin
            last_mem_q <= last_mem_d;
        end
    end
`else
    // MEM is older in program order, so it wins every tie.
    assign pick_mem = bus.mem_req;
`endif

    // Gated by rst so gnt stays low while reset is held with a request up.
    assign grant       = (state_q == S_IDLE) & any_req & ~rst;
    assign bus.mem_gnt = grant & pick_mem;
    assign bus.if_gnt  = grant & ~pick_mem;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d     = S_ISSUE;
                    owner_mem_d = pick_mem;
                    if (pick_mem) begin
                        we_d    = bus.mem_we;
                        addr_d  = bus.mem_addr;
                        wdata_d = bus.mem_wdata;
                        wmask_d = bus.mem_wmask;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_DONE;
                    if (owner_mem_q) begin
                        mem_rdata_d = bus.ram_rdata;
                    end else begin
                        if_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= 2'd0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // RAM side is forced to zero outside ISSUE so it never shows stale data.
    assign issue         = (state_q == S_ISSUE);
    assign bus.ram_en    = issue;
    assign bus.ram_we    = issue & we_q;
    assign bus.ram_addr  = issue ? addr_q : '0;
    assign bus.ram_wdata = issue ? wdata_q : '0;
    assign bus.ram_wmask = issue ? wmask_q : '0;

    assign bus.if_done   = (state_q == S_DONE) & ~owner_mem_q;
    assign bus.mem_done  = (state_q == S_DONE) & owner_mem_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: READ_LAT=1 and READ_LAT=3 instances.
// Honours ARB_RR_EN for the expected tie-break order.
module tb_ram_port_arbiter;
    logic clk;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [63:0] JUNK = 64'hDEADBEEF_0BADF00D;

    ram_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
    ram_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

    ram_port_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    ram_port_arbiter #(.ADDR_W(64), .DATA_W(64), .READ_LAT(3)) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bit exp_mem;
        rst = 1'b1;
        b1.if_req = 0; b1.if_addr = '0;
        b1.mem_req = 0; b1.mem_we = 0; b1.mem_addr = '0;
        b1.mem_wdata = '0; b1.mem_wmask = '0; b1.ram_rdata = JUNK;
        b3.if_req = 0; b3.if_addr = '0;
        b3.mem_req = 0; b3.mem_we = 0; b3.mem_addr = '0;
        b3.mem_wdata = '0; b3.mem_wmask = '0; b3.ram_rdata = JUNK;

        // Reset state
        cyc(); settle();
        chk("rst_if_gnt", 64'(b1.if_gnt), 64'd0);
        chk("rst_mem_gnt", 64'(b1.mem_gnt), 64'd0);
        chk("rst_done", 64'({b1.if_done, b1.mem_done}), 64'd0);
        chk("rst_ram_en", 64'(b1.ram_en), 64'd0);
        chk("rst_ram_addr", b1.ram_addr, 64'd0);
        chk("rst_if_rdata", b1.if_rdata, 64'd0);
        chk("rst_mem_rdata", b1.mem_rdata, 64'd0);
        rst = 1'b0;

        // IF read, READ_LAT=1
        cyc(); b1.if_req = 1; b1.if_addr = 64'h8000_0000; settle();
        chk("ifrd_gnt", 64'(b1.if_gnt), 64'd1);
        chk("ifrd_mem_gnt", 64'(b1.mem_gnt), 64'd0);
        chk("ifrd_c0_en", 64'(b1.ram_en), 64'd0);
        cyc(); settle();
        chk("ifrd_c1_en", 64'(b1.ram_en), 64'd1);
        chk("ifrd_c1_we", 64'(b1.ram_we), 64'd0);
        chk("ifrd_c1_addr", b1.ram_addr, 64'h8000_0000);
        chk("ifrd_c1_mask", b1.ram_wmask, 64'd0);
        chk("ifrd_c1_gnt", 64'(b1.if_gnt), 64'd0);
        cyc(); b1.ram_rdata = 64'h1122334455667788; settle();
        chk("ifrd_c2_en", 64'(b1.ram_en), 64'd0);
        chk("ifrd_c2_addr", b1.ram_addr, 64'd0);
        chk("ifrd_c2_done", 64'(b1.if_done), 64'd0);
        cyc(); b1.ram_rdata = JUNK; settle();
        chk("ifrd_c3_done", 64'(b1.if_done), 64'd1);
        chk("ifrd_c3_rdata", b1.if_rdata, 64'h1122334455667788);
        chk("ifrd_c3_mdone", 64'(b1.mem_done), 64'd0);
        b1.if_req = 0;
        cyc(); settle();
        chk("ifrd_c4_done", 64'(b1.if_done), 64'd0);
        chk("ifrd_c4_gnt", 64'(b1.if_gnt), 64'd0);
        chk("ifrd_c4_hold", b1.if_rdata, 64'h1122334455667788);

        // MEM write
        cyc();
        b1.mem_req = 1; b1.mem_we = 1; b1.mem_addr = 64'h8000_0008;
        b1.mem_wdata = 64'hAB00; b1.mem_wmask = 64'hFF00;
        settle();
        chk("mwr_gnt", 64'(b1.mem_gnt), 64'd1);
        chk("mwr_if_gnt", 64'(b1.if_gnt), 64'd0);
        cyc(); settle();
        chk("mwr_en", 64'(b1.ram_en), 64'd1);
        chk("mwr_we", 64'(b1.ram_we), 64'd1);
        chk("mwr_addr", b1.ram_addr, 64'h8000_0008);
        chk("mwr_wdata", b1.ram_wdata, 64'hAB00);
        chk("mwr_wmask", b1.ram_wmask, 64'hFF00);
        cyc(); settle();
        chk("mwr_done", 64'(b1.mem_done), 64'd1);
        chk("mwr_if_done", 64'(b1.if_done), 64'd0);
        chk("mwr_c2_en", 64'(b1.ram_en), 64'd0);
        b1.mem_req = 0; b1.mem_we = 0;
        cyc(); settle();
        chk("mwr_c3_done", 64'(b1.mem_done), 64'd0);
        chk("mwr_c3_wdata", b1.ram_wdata, 64'd0);
        chk("mwr_c3_we", 64'(b1.ram_we), 64'd0);
        chk("mwr_c3_mrd", b1.mem_rdata, 64'd0);

        // Fresh reset so the last-grant state is known, then repeated ties
        cyc(); rst = 1'b1; #1; rst = 1'b0;
        cyc();
        b1.if_req = 1; b1.if_addr = 64'h100;
        b1.mem_req = 1; b1.mem_we = 0; b1.mem_addr = 64'h200;
        settle();
        for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
            exp_mem = (r % 2 == 0);
`else
            exp_mem = 1'b1;
`endif
            chk("tie_mem_gnt", 64'(b1.mem_gnt), 64'(exp_mem));
            chk("tie_if_gnt", 64'(b1.if_gnt), 64'(!exp_mem));
            cyc(); settle();
            chk("tie_addr", b1.ram_addr, exp_mem ? 64'h200 : 64'h100);
            chk("tie_no_gnt", 64'({b1.if_gnt, b1.mem_gnt}), 64'd0);
            cyc(); b1.ram_rdata = 64'hA0 + 64'(r); settle();
            cyc(); b1.ram_rdata = JUNK;
            if (r == 3) begin
                b1.if_req = 0; b1.mem_req = 0;
            end
            settle();
            chk("tie_mem_done", 64'(b1.mem_done), 64'(exp_mem));
            chk("tie_if_done", 64'(b1.if_done), 64'(!exp_mem));
            chk("tie_rdata", exp_mem ? b1.mem_rdata : b1.if_rdata,
                64'hA0 + 64'(r));
            cyc(); settle();
        end
        chk("tie_idle_gnt", 64'({b1.if_gnt, b1.mem_gnt}), 64'd0);

        // READ_LAT=3 MEM read with an IF request arriving during WAIT
        cyc(); b3.mem_req = 1; b3.mem_we = 0; b3.mem_addr = 64'h300; settle();
        chk("l3_mgnt", 64'(b3.mem_gnt), 64'd1);
        cyc(); settle();
        chk("l3_c1_en", 64'(b3.ram_en), 64'd1);
        chk("l3_c1_addr", b3.ram_addr, 64'h300);
        chk("l3_c1_we", 64'(b3.ram_we), 64'd0);
        cyc(); b3.if_req = 1; b3.if_addr = 64'h400; settle();
        chk("l3_c2_en", 64'(b3.ram_en), 64'd0);
        chk("l3_c2_ignt", 64'(b3.if_gnt), 64'd0);
        cyc(); settle();
        chk("l3_c3_ignt", 64'(b3.if_gnt), 64'd0);
        chk("l3_c3_done", 64'(b3.mem_done), 64'd0);
        chk("l3_c3_en", 64'(b3.ram_en), 64'd0);
        cyc(); b3.ram_rdata = 64'hCAFE_F00D_1234_5678; settle();
        chk("l3_c4_ignt", 64'(b3.if_gnt), 64'd0);
        chk("l3_c4_done", 64'(b3.mem_done), 64'd0);
        cyc(); b3.ram_rdata = JUNK; b3.mem_req = 0; settle();
        chk("l3_c5_done", 64'(b3.mem_done), 64'd1);
        chk("l3_c5_rdata", b3.mem_rdata, 64'hCAFE_F00D_1234_5678);
        chk("l3_c5_ignt", 64'(b3.if_gnt), 64'd0);
        cyc(); settle();
        chk("l3_c6_ignt", 64'(b3.if_gnt), 64'd1);
        chk("l3_c6_mgnt", 64'(b3.mem_gnt), 64'd0);
        chk("l3_c6_mdone", 64'(b3.mem_done), 64'd0);
        cyc(); settle();
        chk("l3_c7_en", 64'(b3.ram_en), 64'd1);
        chk("l3_c7_addr", b3.ram_addr, 64'h400);
        cyc(); settle();

        // Asynchronous reset while in WAIT, IF request held high
        cyc(); settle();
        rst = 1'b1; #1;
        chk("arst_en", 64'(b3.ram_en), 64'd0);
        chk("arst_addr", b3.ram_addr, 64'd0);
        chk("arst_done", 64'({b3.if_done, b3.mem_done}), 64'd0);
        chk("arst_gnt", 64'({b3.if_gnt, b3.mem_gnt}), 64'd0);
        chk("arst_mrd", b3.mem_rdata, 64'd0);
        cyc(); settle();
        chk("arst_hold_done", 64'(b3.if_done), 64'd0);
        chk("arst_hold_gnt", 64'(b3.if_gnt), 64'd0);
        rst = 1'b0; #1;
        chk("post_gnt", 64'(b3.if_gnt), 64'd1);
        cyc(); settle();
        chk("post_en", 64'(b3.ram_en), 64'd1);
        chk("post_addr", b3.ram_addr, 64'h400);
        cyc(); settle();
        chk("post_w1_done", 64'(b3.if_done), 64'd0);
        cyc(); settle();
        chk("post_w2_done", 64'(b3.if_done), 64'd0);
        cyc(); b3.ram_rdata = 64'h5566_7788_99AA_BBCC; settle();
        chk("post_w3_done", 64'(b3.if_done), 64'd0);
        cyc(); b3.ram_rdata = JUNK; b3.if_req = 0; settle();
        chk("post_done", 64'(b3.if_done), 64'd1);
        chk("post_rdata", b3.if_rdata, 64'h5566_7788_99AA_BBCC);
        chk("post_mdone", 64'(b3.mem_done), 64'd0);
        cyc(); settle();
        chk("post_idle_done", 64'(b3.if_done), 64'd0);
        chk("post_idle_gnt", 64'(b3.if_gnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
